// File: rtl/blk_ram_stream_reader_pkg.sv
// Shared definitions for the block-RAM stream reader: FSM encoding,
// default geometry and the FIFO occupancy-counter width helper.
package blk_rd_pkg;

  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 2;

  // FSM encoding kept as plain constants so older blocks can share it.
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;
  localparam logic [STATE_W-1:0] ST_FIN   = 2'd3;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_FIFO_CNT_W = fifo_cnt_w(DEF_FIFO_DEPTH);

endpackage

// File: rtl/blk_ram_stream_reader_fifo.sv
// Small synchronous first-word-fall-through FIFO that buffers block-RAM
// read data in front of the output stream. The head entry is always
// visible on head_data; head_data reads as zero while the FIFO is empty.
module rd_stream_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_FULL);
  assign count     = count_q;
  assign do_pop    = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_push   = push & (~full | do_pop);
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Next pointers and occupancy; push and pop together leave the count unchanged.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array written on accepted pushes.
  always_ff @(posedge clk) begin
    // NOTE: the storage is deliberately not reset; emptiness comes from count_q and the head is masked.
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/blk_ram_stream_reader.sv
// Reads LEN words from a 1-cycle-latency block RAM starting at BASE_ADDR
// and streams them out in address order on valid/ready. Reads are issued
// only while the FIFO plus the read in flight leave room for one more, so
// back-pressure can neither drop nor repeat a word.
module blk_ram_stream_reader
  import blk_rd_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);
  localparam logic [CNT_W:0]    DEPTH_L  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [ADDR_W:0]    rd_left_q, rd_left_d;
  logic [ADDR_W:0]    acc_q, acc_d;
  logic               inflight_q;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty, fifo_full;
  logic               pop;
  logic [CNT_W:0]     occ_next;

  assign pop = out_valid & out_ready;

  // Occupancy after this edge: buffered words plus the word landing now, minus the one leaving.
  assign occ_next = {1'b0, fifo_count}
                  + {{CNT_W{1'b0}}, inflight_q}
                  - {{CNT_W{1'b0}}, pop};

  // A new read is issued only if its data will still find a free slot when it arrives.
  assign mem_en   = (state_q == ST_RUN) && (occ_next < DEPTH_L);
  assign mem_addr = addr_q;

  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_FIN);
  assign out_valid = ~fifo_empty;
  assign out_last  = out_valid && (acc_q == len_q - LEN_ONE);

  rd_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (mem_rdata),
    .pop       (pop),
    .head_data (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Transfer sequencing: IDLE -> RUN -> DRAIN -> FIN, or IDLE -> FIN for an empty transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (len == '0) ? ST_FIN : ST_RUN;
      ST_RUN:   if (mem_en && (rd_left_q == LEN_ONE)) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !inflight_q && (acc_q == len_q)) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture the request at start, then advance the address and both counters as reads and handshakes occur.
  always_comb begin
    addr_d    = addr_q;
    len_d     = len_q;
    rd_left_d = rd_left_q;
    acc_d     = acc_q;
    if ((state_q == ST_IDLE) && start) begin
      addr_d    = base_addr;
      len_d     = len;
      rd_left_d = len;
      acc_d     = '0;
    end
    if (mem_en) begin
      addr_d    = addr_q + ADDR_ONE;
      rd_left_d = rd_left_q - LEN_ONE;
    end
    if (pop) acc_d = acc_q + LEN_ONE;
  end

  // Control and counter registers; reset also discards any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      rd_left_q  <= '0;
      acc_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      rd_left_q  <= rd_left_d;
      acc_q      <= acc_d;
      inflight_q <= mem_en;
    end
  end

  // Arriving read data must never meet a full FIFO that is not draining.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inflight_q && fifo_full && !pop));

endmodule

// File: tb/tb_blk_ram_stream_reader.sv
// Directed bench for blk_ram_stream_reader. RAM holds word i+1 at address i.
// Cycle index k counts clock edges after the edge that samples start.
module tb_blk_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] base_addr;
  logic [6:0] len;
  logic       busy, done, mem_en;
  logic [5:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_last;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [64];

  logic [7:0] got_data [$];
  logic       got_last [$];
  logic [5:0] got_addr [$];
  int first_valid_k, last_hs_k, done_k, done_pulses, stall_bad, busy_cycles;

  blk_ram_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency synchronous RAM model
  always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_addr];

  // Drive start for one cycle; afterwards scribble base/len to prove they were captured.
  task automatic start_xfer(input logic [5:0] b, input logic [6:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 6'h2A;
    len       = 7'd9;
  endtask

  // Run the stream until done (plus 4 tail cycles). ready_mode 0: always ready,
  // 1: ready pattern 1,0,0 repeating. poke_k >= 0 pulses a stray start at that cycle.
  task automatic collect(input int ready_mode, input int max_k, input int poke_k);
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    got_data.delete(); got_last.delete(); got_addr.delete();
    first_valid_k = -1; last_hs_k = -1; done_k = -1;
    done_pulses = 0; stall_bad = 0; busy_cycles = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int k = 0; k < max_k; k++) begin
      out_ready = (ready_mode == 0) ? 1'b1 : ((k % 3) == 0);
      if (k == poke_k) begin
        start = 1'b1; base_addr = 6'd40; len = 7'd3;
      end
      #1;
      if (mem_en) got_addr.push_back(mem_addr);
      if (busy) busy_cycles++;
      if (out_valid && first_valid_k < 0) first_valid_k = k;
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stall_bad++;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        last_hs_k = k + 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) begin
        done_pulses++;
        if (done_k < 0) done_k = k;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done_k >= 0 && k >= done_k + 4) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, mem_en, out_valid, out_last} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: busy/done/mem_en/valid/last=%b expected 00000",
                         {busy, done, mem_en, out_valid, out_last});
    end
    checks++;
    if (mem_addr !== 6'd0 || out_data !== 8'd0) begin
      errors++; $display("FAIL reset_data: mem_addr=%0d out_data=%0d expected 0 0", mem_addr, out_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic       exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    start_xfer(6'd0, 7'd4);
    collect(0, 40, -1);
    checks++;
    if (got_data.size() != 4) begin
      errors++; $display("FAIL basic_count: words=%0d expected 4", got_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
        errors++; $display("FAIL basic_word%0d: data=%0d last=%b expected %0d %b",
                           i, got_data[i], got_last[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (first_valid_k != 2 || last_hs_k != 6) begin
      errors++; $display("FAIL basic_timing: first_valid=%0d last_hs=%0d expected 2 6",
                         first_valid_k, last_hs_k);
    end
    checks++;
    if (done_k != 7 || done_pulses != 1) begin
      errors++; $display("FAIL basic_done: done_k=%0d pulses=%0d expected 7 1", done_k, done_pulses);
    end
    checks++;
    if (busy_cycles != 7) begin
      errors++; $display("FAIL basic_busy: busy cycles=%0d expected 7", busy_cycles);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] exp_a [4] = '{6'd62, 6'd63, 6'd0, 6'd1};
    logic [7:0] exp_d [4] = '{8'd63, 8'd64, 8'd1, 8'd2};
    start_xfer(6'd62, 7'd4);
    collect(0, 40, -1);
    checks++;
    if (got_addr.size() != 4 || got_data.size() != 4) begin
      errors++; $display("FAIL wrap_count: reads=%0d words=%0d expected 4 4", got_addr.size(), got_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_data.size() || i >= got_addr.size() ||
          got_addr[i] !== exp_a[i] || got_data[i] !== exp_d[i]) begin
        errors++; $display("FAIL wrap_word%0d: addr=%0d data=%0d expected %0d %0d",
                           i, got_addr[i], got_data[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if (done_pulses != 1 || got_last.size() != 4 || got_last[3] !== 1'b1) begin
      errors++; $display("FAIL wrap_end: pulses=%0d words=%0d expected 1 4 with last on word 4",
                         done_pulses, got_last.size());
    end
  endtask

  task automatic test_backpressure();
    int bad_words;
    int bad_last;
    start_xfer(6'd8, 7'd8);
    collect(1, 200, -1);
    bad_words = 0; bad_last = 0;
    for (int i = 0; i < got_data.size(); i++) begin
      if (got_data[i] !== 8'(9 + i)) bad_words++;
      if (got_last[i] !== (i == 7)) bad_last++;
    end
    checks++;
    if (got_data.size() != 8 || bad_words != 0) begin
      errors++; $display("FAIL bp_order: words=%0d out_of_order=%0d expected 8 0", got_data.size(), bad_words);
    end
    checks++;
    if (bad_last != 0) begin
      errors++; $display("FAIL bp_last: misplaced last flags=%0d expected 0", bad_last);
    end
    checks++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL bp_stable: stall changes=%0d expected 0", stall_bad);
    end
    checks++;
    if (got_addr.size() != 8 || done_pulses != 1) begin
      errors++; $display("FAIL bp_reads: reads=%0d done pulses=%0d expected 8 1", got_addr.size(), done_pulses);
    end
  endtask

  task automatic test_len_edges();
    int bad_words;
    int n_last;
    // Empty transfer: FIN is entered on the start edge itself.
    start_xfer(6'd3, 7'd0);
    collect(0, 20, -1);
    checks++;
    if (got_addr.size() != 0 || first_valid_k != -1 || busy_cycles != 0) begin
      errors++; $display("FAIL len0_quiet: reads=%0d first_valid=%0d busy=%0d expected 0 -1 0",
                         got_addr.size(), first_valid_k, busy_cycles);
    end
    checks++;
    if (done_k != 0 || done_pulses != 1) begin
      errors++; $display("FAIL len0_done: done_k=%0d pulses=%0d expected 0 1", done_k, done_pulses);
    end
    // Full-memory transfer.
    start_xfer(6'd0, 7'd64);
    collect(0, 200, -1);
    bad_words = 0; n_last = 0;
    for (int i = 0; i < got_data.size(); i++) begin
      if (got_data[i] !== 8'(i + 1)) bad_words++;
      if (got_last[i] === 1'b1) n_last++;
    end
    checks++;
    if (got_data.size() != 64 || bad_words != 0) begin
      errors++; $display("FAIL len64_words: words=%0d bad=%0d expected 64 0", got_data.size(), bad_words);
    end
    checks++;
    if (n_last != 1 || got_last.size() != 64 || got_last[63] !== 1'b1) begin
      errors++; $display("FAIL len64_last: last flags=%0d expected 1 on word 64", n_last);
    end
    checks++;
    if (last_hs_k != 66 || done_k != 67) begin
      errors++; $display("FAIL len64_timing: last_hs=%0d done_k=%0d expected 66 67", last_hs_k, done_k);
    end
  endtask

  task automatic test_start_ignored();
    int bad_words;
    start_xfer(6'd10, 7'd5);
    collect(0, 60, 1);
    bad_words = 0;
    for (int i = 0; i < got_data.size(); i++)
      if (got_data[i] !== 8'(11 + i) || got_addr[i] !== 6'(10 + i)) bad_words++;
    checks++;
    if (got_data.size() != 5 || got_addr.size() != 5 || bad_words != 0) begin
      errors++; $display("FAIL restart_ignored: words=%0d reads=%0d bad=%0d expected 5 5 0",
                         got_data.size(), got_addr.size(), bad_words);
    end
    checks++;
    if (done_pulses != 1 || got_last[4] !== 1'b1) begin
      errors++; $display("FAIL restart_done: pulses=%0d last5=%b expected 1 1", done_pulses, got_last[4]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seen [3];
    int hs;
    int late_done;
    hs = 0;
    start_xfer(6'd20, 7'd8);
    for (int k = 0; k < 50 && hs < 3; k++) begin
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        seen[hs] = out_data;
        hs++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (hs != 3 || seen[0] !== 8'd21 || seen[1] !== 8'd22 || seen[2] !== 8'd23) begin
      errors++; $display("FAIL mid_prefix: words=%0d data=%0d,%0d,%0d expected 3 21,22,23",
                         hs, seen[0], seen[1], seen[2]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, mem_en, out_valid, out_last} !== 5'b0 || mem_addr !== 6'd0 || out_data !== 8'd0) begin
      errors++; $display("FAIL mid_reset: ctrl=%b addr=%0d data=%0d expected 00000 0 0",
                         {busy, done, mem_en, out_valid, out_last}, mem_addr, out_data);
    end
    rst = 1'b0;
    late_done = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (done || out_valid || mem_en) late_done++;
      @(posedge clk); #1;
    end
    checks++;
    if (late_done != 0) begin
      errors++; $display("FAIL mid_quiet: activity cycles after reset=%0d expected 0", late_done);
    end
    start_xfer(6'd50, 7'd3);
    collect(0, 40, -1);
    checks++;
    if (got_data.size() != 3 || got_data[0] !== 8'd51 || got_data[1] !== 8'd52 || got_data[2] !== 8'd53) begin
      errors++; $display("FAIL mid_restart: words=%0d data=%0d,%0d,%0d expected 3 51,52,53",
                         got_data.size(), got_data[0], got_data[1], got_data[2]);
    end
    checks++;
    if (first_valid_k != 2 || done_pulses != 1) begin
      errors++; $display("FAIL mid_restart_timing: first_valid=%0d pulses=%0d expected 2 1",
                         first_valid_k, done_pulses);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'(i + 1);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_edges();
    test_start_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
